ura_multiport_regfile: RTL and testbench
========================================

// Module: ura_multiport_regfile
// PURPOSE
//  Parametrised universal register array: one byte-enabled write port plus NUM_RD independent read ports.
//  Adds a hardware init/clear sequencer with a busy flag, same-cycle write-to-read forwarding and
//  out-of-range address detection. Sits between the bus front-end and datapath consumers.
// PARAMETERS
//  DEPTH       16   number of entries (need not be a power of 2; >=2)
//  DATA_WIDTH  32   entry width in bits; multiple of 8
//  NUM_RD      2    number of read ports (>=1)
//  INIT_VAL    0    value written to every entry by the init/clear sequence
//  (local) AW = $clog2(DEPTH); BE = DATA_WIDTH/8
// PORTS
//  clk         in   1             clock
//  rst         in   1             synchronous reset, active high
//  write_en    in   1             write request
//  write_addr  in   AW            write entry index
//  write_data  in   DATA_WIDTH    write data
//  write_be    in   BE            byte enables; bit i covers data[8i+7:8i]
//  read_en     in   NUM_RD        per-port read request
//  read_addr   in   NUM_RD*AW     port p address at [p*AW +: AW]
//  clear_req   in   1             request to reload all entries with INIT_VAL
//  read_data   out  NUM_RD*DATA_WIDTH   port p data at [p*DATA_WIDTH +: DATA_WIDTH]
//  read_valid  out  NUM_RD        per-port 1-cycle pulse; read_data valid
//  read_err    out  NUM_RD        per-port 1-cycle pulse; address >= DEPTH
//  busy        out  1             sequencer active; all requests ignored
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=INIT, ptr=0, busy=1, read_valid=0, read_err=0, read_data=0.
//   - Array contents are not reset directly; the INIT walk overwrites them.
//  FSM:
//   - INIT/CLEAR: each cycle entry[ptr]<=INIT_VAL, ptr++; at ptr==DEPTH-1 go IDLE, ptr<=0.
//   - busy=1 in INIT/CLEAR, so busy stays high for exactly DEPTH cycles after rst falls.
//   - IDLE: clear_req=1 -> CLEAR next cycle (busy rises the cycle after sampling).
//   - clear_req while busy is ignored (not queued).
//  Write (IDLE only):
//   - write_en & write_addr<DEPTH -> update bytes with write_be=1 at posedge; other bytes hold.
//   - write_be=0 is a no-op. Out-of-range writes are silently dropped.
//  Read (IDLE only), latency 1 cycle:
//   - read_en[p] sampled at edge N -> read_valid[p]=1 during cycle N+1 with entry contents.
//   - read_data[p] holds its last value when read_valid[p]=0.
//   - Same-cycle write to the same address: write-first. Returned data is the merge of old data
//     and enabled write bytes. All ports may read one address simultaneously.
//   - read_addr[p]>=DEPTH -> read_valid[p]=1, read_err[p]=1, read_data[p]=0.
//  Interactions:
//   - While busy, write_en/read_en are dropped: no valid, no err, no array change.
//   - IDLE with clear_req & write_en in the same cycle: the write completes, then CLEAR overwrites it.
//   - Reads that cycle return pre-clear (forwarded) data.
//   - rst mid-CLEAR restarts INIT from ptr 0; pending read pulses are cancelled.
// TESTING  (DEPTH=16, DATA_WIDTH=32, NUM_RD=2, INIT_VAL=0 unless stated)
//  1. Release rst -> busy=1 for 16 cycles, then 0; read all 16 addresses on both ports -> all 0x00000000.
//  2. Write addr 5 0xDEADBEEF be=4'hF; next cycle read p0 addr5 -> valid one cycle later, 0xDEADBEEF.
//     Then write be=4'b0010 data 0x0000AA00 -> read 0xDEADAAEF.
//  3. Same cycle: write addr3 0x12345678 be=4'hF, p0 and p1 both read addr3 -> both return 0x12345678
//     next cycle (forwarding).
//  4. DEPTH=12: p1 read addr 13, write addr 14 -> read_err[1]=1, read_valid[1]=1, data 0.
//     Entries 0..11 unchanged.
//  5. INIT_VAL=32'hA5A5A5A5: fill entries; pulse clear_req together with write addr2 0x1 ->
//     busy high 16 cycles; writes/reads during busy give no valid. All entries then read 0xA5A5A5A5.
//  6. Assert rst at clear step 7 -> busy stays 1, full 16-cycle INIT restarts; read_valid=0 throughout.

Source files
------------

// File: rtl/ura_multiport_regfile.sv
// Register array with one byte-enabled write port and NUM_RD read ports.
// Includes an init/clear walker, write-first forwarding and out-of-range address flagging.
module ura_multiport_regfile #(
    parameter int DEPTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0,
    localparam int AW = $clog2(DEPTH),
    localparam int BE = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         write_en,
    input  logic [AW-1:0]                write_addr,
    input  logic [DATA_WIDTH-1:0]        write_data,
    input  logic [BE-1:0]                write_be,
    input  logic [NUM_RD-1:0]            read_en,
    input  logic [NUM_RD*AW-1:0]         read_addr,
    input  logic                         clear_req,
    output logic [NUM_RD*DATA_WIDTH-1:0] read_data,
    output logic [NUM_RD-1:0]            read_valid,
    output logic [NUM_RD-1:0]            read_err,
    output logic                         busy
);

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_INIT, S_CLEAR, S_IDLE} state_t;

    state_t                  state;
    logic [AW-1:0]           ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   wmask;
    logic                    wr_ok;
    logic [AW-1:0]           rd_addr [NUM_RD];
    logic [DATA_WIDTH-1:0]   rd_word [NUM_RD];
    logic [NUM_RD-1:0]       rd_oob;

    assign busy  = (state != S_IDLE);
    assign wr_ok = !busy && write_en && ({1'b0, write_addr} < DEPTH_W);

    always_comb begin
        wmask = '0;
        for (int b = 0; b < BE; b++) begin
            wmask[8*b +: 8] = {8{write_be[b]}};
        end
    end

    // Read path returns the post-write view of an entry being written this cycle
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_addr[p] = read_addr[p*AW +: AW];
            rd_oob[p]  = !({1'b0, rd_addr[p]} < DEPTH_W);
            rd_word[p] = '0;
            if (!rd_oob[p]) begin
                rd_word[p] = mem[rd_addr[p]];
                if (wr_ok && (write_addr == rd_addr[p])) begin
                    rd_word[p] = (rd_word[p] & ~wmask) | (write_data & wmask);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) begin
                mem[ptr] <= INIT_VAL;
            end else if (wr_ok) begin
                mem[write_addr] <= (mem[write_addr] & ~wmask) | (write_data & wmask);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_INIT;
            ptr        <= '0;
            read_valid <= '0;
            read_err   <= '0;
            read_data  <= '0;
        end else begin
            read_valid <= '0;
            read_err   <= '0;
            case (state)
                S_INIT, S_CLEAR: begin
                    if (ptr == PTR_LAST) begin
                        state <= S_IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                S_IDLE: begin
                    for (int p = 0; p < NUM_RD; p++) begin
                        if (read_en[p]) begin
                            read_valid[p]                          <= 1'b1;
                            read_err[p]                            <= rd_oob[p];
                            read_data[p*DATA_WIDTH +: DATA_WIDTH]  <= rd_word[p];
                        end
                    end
                    if (clear_req) begin
                        state <= S_CLEAR;
                        ptr   <= '0;
                    end
                end
                default: begin
                    state <= S_INIT;
                    ptr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ura_multiport_regfile.sv
// Bench for ura_multiport_regfile: three instances (16/INIT 0, 12/INIT 0, 16/INIT A5A5A5A5)
// share stimulus, gated by sel, and are checked against a behavioural model plus a vector table.
module tb_ura_multiport_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_en;
    logic [3:0]  write_addr;
    logic [31:0] write_data;
    logic [3:0]  write_be;
    logic [1:0]  read_en;
    logic [7:0]  read_addr;
    logic        clear_req;
    int          sel;

    logic        we_g   [3];
    logic [1:0]  ren_g  [3];
    logic        clr_g  [3];
    logic [63:0] rdata  [3];
    logic [1:0]  rvalid [3];
    logic [1:0]  rerr   [3];
    logic        busy_o [3];

    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            we_g[i]  = write_en && (sel == i);
            ren_g[i] = (sel == i) ? read_en : 2'b00;
            clr_g[i] = clear_req && (sel == i);
        end
    end

    ura_multiport_regfile #(.DEPTH(16), .DATA_WIDTH(32), .NUM_RD(2), .INIT_VAL(32'h0)) u_dut0 (
        .clk(clk), .rst(rst), .write_en(we_g[0]), .write_addr(write_addr), .write_data(write_data),
        .write_be(write_be), .read_en(ren_g[0]), .read_addr(read_addr), .clear_req(clr_g[0]),
        .read_data(rdata[0]), .read_valid(rvalid[0]), .read_err(rerr[0]), .busy(busy_o[0]));

    ura_multiport_regfile #(.DEPTH(12), .DATA_WIDTH(32), .NUM_RD(2), .INIT_VAL(32'h0)) u_dut1 (
        .clk(clk), .rst(rst), .write_en(we_g[1]), .write_addr(write_addr), .write_data(write_data),
        .write_be(write_be), .read_en(ren_g[1]), .read_addr(read_addr), .clear_req(clr_g[1]),
        .read_data(rdata[1]), .read_valid(rvalid[1]), .read_err(rerr[1]), .busy(busy_o[1]));

    ura_multiport_regfile #(.DEPTH(16), .DATA_WIDTH(32), .NUM_RD(2), .INIT_VAL(32'hA5A5A5A5)) u_dut2 (
        .clk(clk), .rst(rst), .write_en(we_g[2]), .write_addr(write_addr), .write_data(write_data),
        .write_be(write_be), .read_en(ren_g[2]), .read_addr(read_addr), .clear_req(clr_g[2]),
        .read_data(rdata[2]), .read_valid(rvalid[2]), .read_err(rerr[2]), .busy(busy_o[2]));

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  e;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b;
    } exp_t;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  wbe;
        logic [1:0]  ren;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic        chk0;
        logic [31:0] exp0;
        logic        chk1;
        logic [31:0] exp1;
    } vec_t;

    exp_t        sbq [$];
    logic [31:0] mdl  [3][16];
    logic [31:0] last [3][2];
    int          cnt  [3];
    int          depth_of [3] = '{16, 12, 16};
    logic [31:0] init_of  [3] = '{32'h0, 32'h0, 32'hA5A5A5A5};
    vec_t        tbl [10];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s (dut%0d): got %h, expected %h", name, sel, act, exp);
    endtask

    task automatic checkOutput();
        exp_t x;
        if (sbq.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        x = sbq.pop_front();
        check("busy",     {63'd0, busy_o[sel]}, {63'd0, x.b});
        check("valid",    {62'd0, rvalid[sel]}, {62'd0, x.v});
        check("err",      {62'd0, rerr[sel]},   {62'd0, x.e});
        check("data_p0",  {32'd0, rdata[sel][31:0]},  {32'd0, x.d0});
        check("data_p1",  {32'd0, rdata[sel][63:32]}, {32'd0, x.d1});
    endtask

    // One clock: drive, predict this edge for every instance, then compare after the edge
    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                 input logic [3:0] wbe, input logic [1:0] ren,
                                 input logic [3:0] ra0, input logic [3:0] ra1, input logic clr);
        exp_t        x;
        logic [3:0]  ra;
        logic [31:0] w;
        logic        wok;
        write_en   = we;
        write_addr = wa;
        write_data = wd;
        write_be   = wbe;
        read_en    = ren;
        read_addr  = {ra1, ra0};
        clear_req  = clr;
        for (int i = 0; i < 3; i++) begin
            x.v = 2'b00;
            x.e = 2'b00;
            wok = we && (int'(wa) < depth_of[i]);
            if (rst) begin
                cnt[i] = depth_of[i];
                for (int a = 0; a < 16; a++) mdl[i][a] = init_of[i];
                last[i][0] = '0;
                last[i][1] = '0;
            end else if (cnt[i] > 0) begin
                cnt[i]--;
            end else if (i == sel) begin
                for (int p = 0; p < 2; p++) begin
                    if (ren[p]) begin
                        ra     = (p == 0) ? ra0 : ra1;
                        x.v[p] = 1'b1;
                        if (int'(ra) >= depth_of[i]) begin
                            x.e[p]     = 1'b1;
                            last[i][p] = '0;
                        end else begin
                            w = mdl[i][ra];
                            if (wok && wa == ra) w = merge(w, wd, wbe);
                            last[i][p] = w;
                        end
                    end
                end
                if (wok) mdl[i][wa] = merge(mdl[i][wa], wd, wbe);
                if (clr) begin
                    for (int a = 0; a < 16; a++) mdl[i][a] = init_of[i];
                    cnt[i] = depth_of[i];
                end
            end
            x.d0 = last[i][0];
            x.d1 = last[i][1];
            x.b  = (cnt[i] > 0);
            if (i == sel) sbq.push_back(x);
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 2'b00, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic readAll(input int depth);
        for (int a = 0; a < depth; a++) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 2'b11, 4'(a), 4'(depth - 1 - a), 1'b0);
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 4'd5,  32'hDEADBEEF, 4'hF,    2'b00, 4'd0, 4'd0,  1'b0, 32'h0,        1'b0, 32'h0};
        tbl[1] = '{1'b0, 4'd0,  32'h0,        4'h0,    2'b01, 4'd5, 4'd0,  1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 4'd5,  32'h0000AA00, 4'b0010, 2'b00, 4'd0, 4'd0,  1'b0, 32'h0,        1'b0, 32'h0};
        tbl[3] = '{1'b0, 4'd0,  32'h0,        4'h0,    2'b01, 4'd5, 4'd0,  1'b1, 32'hDEADAAEF, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 4'd3,  32'h12345678, 4'hF,    2'b11, 4'd3, 4'd3,  1'b1, 32'h12345678, 1'b1, 32'h12345678};
        tbl[5] = '{1'b1, 4'd3,  32'hFFFFFFFF, 4'h0,    2'b10, 4'd0, 4'd3,  1'b1, 32'h12345678, 1'b1, 32'h12345678};
        tbl[6] = '{1'b1, 4'd7,  32'hCAFEF00D, 4'b1001, 2'b11, 4'd7, 4'd5,  1'b1, 32'hCA00000D, 1'b1, 32'hDEADAAEF};
        tbl[7] = '{1'b0, 4'd0,  32'h0,        4'h0,    2'b11, 4'd7, 4'd3,  1'b1, 32'hCA00000D, 1'b1, 32'h12345678};
        tbl[8] = '{1'b1, 4'd15, 32'h11223344, 4'hF,    2'b10, 4'd0, 4'd15, 1'b1, 32'hCA00000D, 1'b1, 32'h11223344};
        tbl[9] = '{1'b1, 4'd0,  32'h00770000, 4'b0100, 2'b11, 4'd0, 4'd5,  1'b1, 32'h00770000, 1'b1, 32'hDEADAAEF};

        sel = 0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        $display("[TB] init walk and reset contents");
        idle(16);
        readAll(16);

        $display("[TB] vector table: byte enables, forwarding, hold");
        foreach (tbl[r]) begin
            applyStimulus(tbl[r].we, tbl[r].wa, tbl[r].wd, tbl[r].wbe, tbl[r].ren,
                          tbl[r].ra0, tbl[r].ra1, 1'b0);
            if (tbl[r].chk0) check("tbl_p0", {32'd0, rdata[sel][31:0]},  {32'd0, tbl[r].exp0});
            if (tbl[r].chk1) check("tbl_p1", {32'd0, rdata[sel][63:32]}, {32'd0, tbl[r].exp1});
        end

        $display("[TB] out-of-range addressing on 12-entry array");
        sel = 1;
        for (int a = 0; a < 12; a++) applyStimulus(1'b1, 4'(a), 32'h100 + 32'(a), 4'hF, 2'b00, 4'd0, 4'd0, 1'b0);
        applyStimulus(1'b1, 4'd14, 32'hFFFFFFFF, 4'hF, 2'b10, 4'd0, 4'd13, 1'b0);
        check("oob_err_p1",   {62'd0, rerr[sel]},   64'd2);
        check("oob_valid_p1", {62'd0, rvalid[sel]}, 64'd2);
        applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 2'b11, 4'd12, 4'd11, 1'b0);
        readAll(12);

        $display("[TB] clear with concurrent write, INIT_VAL A5A5A5A5");
        sel = 2;
        for (int a = 0; a < 16; a++) applyStimulus(1'b1, 4'(a), 32'h01010101 * 32'(a), 4'hF, 2'b00, 4'd0, 4'd0, 1'b0);
        applyStimulus(1'b1, 4'd2, 32'h00000001, 4'hF, 2'b01, 4'd2, 4'd0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 4'(k), 32'h5555AAAA, 4'hF, 2'b11, 4'(k), 4'(15 - k), (k == 3));
        end
        readAll(16);

        $display("[TB] reset during clear");
        sel = 0;
        applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 2'b00, 4'd0, 4'd0, 1'b1);
        idle(7);
        rst = 1'b1;
        applyStimulus(1'b1, 4'd9, 32'h99999999, 4'hF, 2'b11, 4'd5, 4'd3, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 2'b11, 4'(k), 4'(k), 1'b0);
        readAll(16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
